// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the cpu imem/dmem ports and the backing-memory port seen by mem_port_arbiter.
// Latency: none, wires only.
// Backpressure: cpu holds its request until the resp pulse; memory stalls by withholding mem_resp.
interface mem_port_arbiter_if;
   // cpu instruction port
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   // cpu data port
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   // shared backing memory
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        mem_timeout;

   // Arbiter view: serves the cpu ports and drives the memory.
   modport slave (
      input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
             mem_rdata, mem_resp,
      output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
             mem_addr, mem_read, mem_write, mem_wmask, mem_wdata, mem_timeout
   );

   // Environment view: cpu plus memory.
   modport master (
      output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
             mem_rdata, mem_resp,
      input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
             mem_addr, mem_read, mem_write, mem_wmask, mem_wdata, mem_timeout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: serves cpu imem/dmem from one single-ported memory; MEM_ARB_RR_EN selects round-robin instead of fixed dmem priority.
// Latency: resp pulse 2+k cycles after the request is seen in IDLE (k = memory wait cycles); back-to-back grants 3 cycles apart.
// Backpressure: cpu holds its request until resp; memory stalls via mem_resp; sticky mem_timeout after TIMEOUT_CYCLES wait cycles.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 11
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t           state;
   state_t           state_nxt;
   logic             imem_req;
   logic             dmem_req;
   logic             any_req;
   logic             pick_dmem;
   logic             grant;
   logic             lat_dmem;
   logic             lat_write;
   logic [31:0]      lat_addr;
   logic [3:0]       lat_wmask;
   logic [31:0]      lat_wdata;
   logic [31:0]      lat_rdata;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_flag;

   // A store is pending whenever any write byte is enabled, and it wins over a read mask.
   assign imem_req = |bus.imem_rmask;
   assign dmem_req = (|bus.dmem_rmask) | (|bus.dmem_wmask);
   assign any_req  = imem_req | dmem_req;
   assign grant    = (state == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
   logic last_dmem;

   // On a tie the port that did not win last time is granted.
   always_comb begin
      pick_dmem = dmem_req;
      if (dmem_req && imem_req) begin
         pick_dmem = ~last_dmem;
      end
   end

   // Remember the winner of the most recent grant (reset favours dmem next).
   always_ff @(posedge clk) begin
      if (rst) begin
         last_dmem <= 1'b0;
      end else if (grant) begin
         last_dmem <= pick_dmem;
      end
   end
`else
   // Fixed priority: dmem belongs to the older instruction in the pipeline.
   assign pick_dmem = dmem_req;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: only IDLE looks at requests, only BUSY looks at mem_resp.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (bus.mem_resp) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the granted request and later the memory's read data, so cpu input churn cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_dmem  <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wmask <= '0;
         lat_wdata <= '0;
         lat_rdata <= '0;
      end else begin
         if (grant) begin
            lat_dmem <= pick_dmem;
            if (pick_dmem) begin
               lat_addr  <= bus.dmem_addr;
               lat_write <= |bus.dmem_wmask;
               lat_wmask <= bus.dmem_wmask;
               lat_wdata <= (|bus.dmem_wmask) ? bus.dmem_wdata : '0;
            end else begin
               lat_addr  <= bus.imem_addr;
               lat_write <= 1'b0;
               lat_wmask <= '0;
               lat_wdata <= '0;
            end
         end
         if ((state == BUSY) && bus.mem_resp) begin
            lat_rdata <= lat_write ? '0 : bus.mem_rdata;
         end
      end
   end

   // Count BUSY cycles without an answer; the timeout flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else if (grant) begin
         wait_cnt <= '0;
      end else if ((state == BUSY) && !bus.mem_resp && (wait_cnt != TIMEOUT_LIM)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
         if ((wait_cnt + CNT_W'(1)) == TIMEOUT_LIM) begin
            timeout_flag <= 1'b1;
         end
      end
   end

   // Memory strobes only in BUSY; a single resp pulse on the granted port in DONE.
   always_comb begin
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wmask   = '0;
      bus.mem_wdata   = '0;
      bus.imem_resp   = 1'b0;
      bus.imem_rdata  = '0;
      bus.dmem_resp   = 1'b0;
      bus.dmem_rdata  = '0;
      bus.mem_timeout = timeout_flag;
      if (state == BUSY) begin
         bus.mem_read  = ~lat_write;
         bus.mem_write = lat_write;
         bus.mem_addr  = lat_addr & 32'hFFFF_FFFC;
         bus.mem_wmask = lat_wmask;
         bus.mem_wdata = lat_wdata;
      end
      if (state == DONE) begin
         if (lat_dmem) begin
            bus.dmem_resp  = 1'b1;
            bus.dmem_rdata = lat_rdata;
         end else begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = lat_rdata;
         end
      end
   end
endmodule
